// File: rtl/equation_tracker_if.sv
// equation_tracker_if
//   Bundles the game-logic signals exchanged between the collision stage,
//   the equation tracker and the rest of the VGA game logic.
//   Ports (slave = tracker side):
//     startOfFrame    in   one-clock pulse at frame start
//     SingleHitPulse  in   NUMBERS one-clock number-hit pulses
//     numberValues    in   packed number values, slice i = [i*VAL_W +: VAL_W]
//     operandHit      in   bit0 = plus, bit1 = minus pulses
//     waterCollision  in   monkey overlapping water (level)
//     target          in   level goal
//     accumulator     out  current result
//     pendingOp       out  0 = plus, 1 = minus
//     expectNumber    out  tracker waiting for a number
//     score           out  completed levels (saturating)
//     lives           out  remaining lives
//     levelDone       out  one-clock pulse when target reached
//     respawn         out  high while in respawn hold
//     gameOver        out  high once out of lives
//     numberConsumed  out  one-clock pulse per accepted number object
interface equation_tracker_if #(
    parameter int unsigned NUMBERS = 3,
    parameter int unsigned VAL_W   = 4,
    parameter int unsigned ACC_W   = 7
);
    logic                       startOfFrame;
    logic [NUMBERS-1:0]         SingleHitPulse;
    logic [NUMBERS*VAL_W-1:0]   numberValues;
    logic [1:0]                 operandHit;
    logic                       waterCollision;
    logic [ACC_W-1:0]           target;
    logic [ACC_W-1:0]           accumulator;
    logic                       pendingOp;
    logic                       expectNumber;
    logic [7:0]                 score;
    logic [1:0]                 lives;
    logic                       levelDone;
    logic                       respawn;
    logic                       gameOver;
    logic [NUMBERS-1:0]         numberConsumed;

    modport slave (
        input  startOfFrame, SingleHitPulse, numberValues, operandHit,
               waterCollision, target,
        output accumulator, pendingOp, expectNumber, score, lives,
               levelDone, respawn, gameOver, numberConsumed
    );

    modport master (
        output startOfFrame, SingleHitPulse, numberValues, operandHit,
               waterCollision, target,
        input  accumulator, pendingOp, expectNumber, score, lives,
               levelDone, respawn, gameOver, numberConsumed
    );
endinterface

// File: rtl/equation_tracker.sv
// equation_tracker
//   Builds the running arithmetic result of the monkey's number/operator
//   pickups, compares it with the level target, and tracks score, lives,
//   respawn hold and game over.
//   Ports:
//     clk     in  system clock
//     resetN  in  synchronous active-low reset
//     bus     equation_tracker_if.slave, see the interface for signal list
module equation_tracker #(
    parameter int unsigned NUMBERS        = 3,
    parameter int unsigned VAL_W          = 4,
    parameter int unsigned ACC_W          = 7,
    parameter int unsigned ACC_MAX        = 99,
    parameter int unsigned LIVES_INIT     = 3,
    parameter int unsigned RESPAWN_FRAMES = 60
) (
    input  logic                clk,
    input  logic                resetN,
    equation_tracker_if.slave   bus
);
    localparam int unsigned CNT_W = (RESPAWN_FRAMES > 1) ? $clog2(RESPAWN_FRAMES) : 1;
    localparam logic signed [ACC_W:0] ACC_MAX_S = (ACC_W+1)'(ACC_MAX);

    typedef enum logic [2:0] {
        EXPECT_NUM,
        EXPECT_OP,
        CHECK,
        DEATH,
        RESPAWN,
        GAME_OVER
    } state_t;

    state_t                 state_q, state_nxt;
    logic [ACC_W-1:0]       acc_q, acc_nxt;
    logic signed [ACC_W:0]  next_q, next_nxt;   // signed result kept for the range test in CHECK
    logic                   op_q, op_nxt;
    logic [7:0]             score_q, score_nxt;
    logic [1:0]             lives_q, lives_nxt;
    logic [CNT_W-1:0]       cnt_q, cnt_nxt;
    logic                   done_q, done_nxt;
    logic [NUMBERS-1:0]     consumed_q, consumed_nxt;

    logic [NUMBERS-1:0]     hit_onehot;
    logic [VAL_W-1:0]       hit_val;
    logic signed [ACC_W:0]  acc_ext, val_ext, calc;
    logic                   op_any, op_sel;

    // Lowest set hit index wins; the rest are dropped this clock.
    always_comb begin
        hit_onehot = bus.SingleHitPulse & (~bus.SingleHitPulse + NUMBERS'(1));
        hit_val    = '0;
        for (int unsigned i = 0; i < NUMBERS; i++) begin
            if (hit_onehot[i]) begin
                hit_val = bus.numberValues[i*VAL_W +: VAL_W];
            end
        end
        acc_ext = {1'b0, acc_q};
        val_ext = {{(ACC_W+1-VAL_W){1'b0}}, hit_val};
        calc    = op_q ? (acc_ext - val_ext) : (acc_ext + val_ext);
        op_any  = |bus.operandHit;
        op_sel  = ~bus.operandHit[0];   // plus has priority when both are set
    end

    always_comb begin
        state_nxt    = state_q;
        acc_nxt      = acc_q;
        next_nxt     = next_q;
        op_nxt       = op_q;
        score_nxt    = score_q;
        lives_nxt    = lives_q;
        cnt_nxt      = cnt_q;
        done_nxt     = 1'b0;
        consumed_nxt = '0;

        unique case (state_q)
            EXPECT_NUM: begin
                if (bus.waterCollision) begin
                    state_nxt = DEATH;
                end else begin
                    if (op_any) begin
                        op_nxt = op_sel;
                    end
                    if (|bus.SingleHitPulse) begin
                        acc_nxt      = calc[ACC_W-1:0];
                        next_nxt     = calc;
                        consumed_nxt = hit_onehot;
                        state_nxt    = CHECK;
                    end
                end
            end
            EXPECT_OP: begin
                if (bus.waterCollision) begin
                    state_nxt = DEATH;
                end else if (op_any) begin
                    op_nxt    = op_sel;
                    state_nxt = EXPECT_NUM;
                end
            end
            CHECK: begin
                if (bus.waterCollision) begin
                    state_nxt = DEATH;
                end else if (next_q[ACC_W] || (next_q > ACC_MAX_S)) begin
                    state_nxt = DEATH;
                end else if (acc_q == bus.target) begin
                    done_nxt  = 1'b1;
                    if (score_q != 8'hFF) begin
                        score_nxt = score_q + 8'd1;
                    end
                    acc_nxt   = '0;
                    op_nxt    = 1'b0;
                    state_nxt = EXPECT_NUM;
                end else begin
                    state_nxt = EXPECT_OP;
                end
            end
            DEATH: begin
                lives_nxt = lives_q - 2'd1;
                acc_nxt   = '0;
                op_nxt    = 1'b0;
                if (lives_q == 2'd1) begin
                    state_nxt = GAME_OVER;
                end else begin
                    cnt_nxt   = '0;
                    state_nxt = RESPAWN;
                end
            end
            RESPAWN: begin
                if (bus.startOfFrame) begin
                    if (cnt_q == CNT_W'(RESPAWN_FRAMES - 1)) begin
                        state_nxt = EXPECT_NUM;
                    end else begin
                        cnt_nxt = cnt_q + CNT_W'(1);
                    end
                end
            end
            GAME_OVER: begin
            end
            default: begin
                state_nxt = EXPECT_NUM;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetN) begin
            state_q    <= EXPECT_NUM;
            acc_q      <= '0;
            next_q     <= '0;
            op_q       <= 1'b0;
            score_q    <= '0;
            lives_q    <= 2'(LIVES_INIT);
            cnt_q      <= '0;
            done_q     <= 1'b0;
            consumed_q <= '0;
        end else begin
            state_q    <= state_nxt;
            acc_q      <= acc_nxt;
            next_q     <= next_nxt;
            op_q       <= op_nxt;
            score_q    <= score_nxt;
            lives_q    <= lives_nxt;
            cnt_q      <= cnt_nxt;
            done_q     <= done_nxt;
            consumed_q <= consumed_nxt;
        end
    end

    assign bus.accumulator    = acc_q;
    assign bus.pendingOp      = op_q;
    assign bus.expectNumber   = (state_q == EXPECT_NUM);
    assign bus.score          = score_q;
    assign bus.lives          = lives_q;
    assign bus.levelDone      = done_q;
    assign bus.respawn        = (state_q == RESPAWN);
    assign bus.gameOver       = (state_q == GAME_OVER);
    assign bus.numberConsumed = consumed_q;
endmodule
